decode_pipe_stage: RTL and testbench

Parametrised, pipelined MIPS instruction-decode stage sitting between fetch and execute. It accepts one 32-bit instruction per cycle over a valid/ready handshake and reads the register file with write-back bypass. It generates the 9-bit control bundle and extends the immediate, then presents everything in a registered ID/EX slot. Adds load-use stall detection, flush, and back-pressure.

---
 rtl/decode_pipe_stage_pkg.sv | 49 ++++
 rtl/decode_pipe_stage_if.sv | 45 ++++
 rtl/decode_pipe_stage_regfile.sv | 35 +++
 rtl/decode_pipe_stage.sv | 127 ++++++++++++
 tb/tb_decode_pipe_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pipe_stage_pkg.sv
// decode_pipe_stage_pkg: shared opcode constants, control-bundle layout and ALU-op encodings
// for the decode stage.
//   OP_*        6-bit primary opcodes that the stage decodes
//   CTRL_*      bit positions inside the 9-bit control bundle
//   aluop_e     AluOp encodings: add, sub, funct-driven, logical-immediate
//   CTRL_<kind> complete control bundles for each decoded instruction class
package decode_pipe_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam int CTRL_W        = 9;
    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_LSB = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_LOGIC = 2'b11
    } aluop_e;

    function automatic ctrl_t mk_ctrl(input logic regdst, input logic alusrc, input logic memtoreg,
                                      input logic regwrite, input logic memread, input logic memwrite,
                                      input logic branch, input aluop_e aluop);
        return {regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop};
    endfunction

    localparam ctrl_t CTRL_R    = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_FUNCT);
    localparam ctrl_t CTRL_LW   = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD);
    localparam ctrl_t CTRL_SW   = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
    localparam ctrl_t CTRL_BEQ  = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB);
    localparam ctrl_t CTRL_ADDI = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD);
    localparam ctrl_t CTRL_LOGI = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_LOGIC);

endpackage

// File: rtl/decode_pipe_stage_if.sv
// decode_pipe_stage_if: fetch-side handshake, write-back port and ID/EX slot of the decode stage.
//   in_valid/in_ready/in_instr   instruction handshake from fetch
//   flush                        discard slot and incoming instruction
//   wb_en/wb_addr/wb_data        register write-back
//   out_valid/out_ready          ID/EX slot handshake towards execute
//   out_ctrl..out_illegal        decoded slot contents
//   modport slave  = decode stage, modport master = surrounding pipeline
interface decode_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
);
    import decode_pipe_stage_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              flush;
    logic              wb_en;
    logic [RA_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    ctrl_t             out_ctrl;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [RA_W-1:0]   out_rt;
    logic [RA_W-1:0]   out_rd;
    logic [4:0]        out_shamt;
    logic [5:0]        out_funct;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_instr, flush, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_rs_data, out_rt_data, out_imm,
               out_rt, out_rd, out_shamt, out_funct, out_illegal
    );

    modport master (
        output in_valid, in_instr, flush, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_rs_data, out_rt_data, out_imm,
               out_rt, out_rd, out_shamt, out_funct, out_illegal
    );

endinterface

// File: rtl/decode_pipe_stage_regfile.sv
// decode_regfile: REG_CNT x DATA_W register file, two async reads with write-first bypass.
//   Clk, Rst_n   clock, asynchronous active-low clear of all registers
//   we/wa/wd     synchronous write port (writes to register 0 are dropped)
//   ra0/rd0      read port 0, ra1/rd1 read port 1
module decode_regfile #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int RA_W    = $clog2(REG_CNT)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              we,
    input  logic [RA_W-1:0]   wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [RA_W-1:0]   ra0,
    input  logic [RA_W-1:0]   ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1
);

    logic [DATA_W-1:0] regs [REG_CNT];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    // A write landing this cycle is forwarded so a same-cycle decode sees the new value.
    assign rd0 = (ra0 == '0) ? '0 : (we && wa == ra0) ? wd : regs[ra0];
    assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : regs[ra1];

endmodule

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: MIPS instruction-decode stage with registered ID/EX slot.
//   Clk, Rst_n   clock, asynchronous active-low reset
//   bus (slave)  fetch handshake, flush, write-back port and ID/EX slot outputs
// Decodes the 9-bit control bundle, extends the immediate, reads operands with
// write-back bypass, and stalls one cycle on a load-use dependency.
module decode_pipe_stage
    import decode_pipe_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_CNT    = 32,
    parameter int LOGIC_ZEXT = 1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    decode_pipe_stage_if.slave  bus
);

    localparam int RA_W = $clog2(REG_CNT);

    logic [5:0]        op;
    logic [RA_W-1:0]   rs_a;
    logic [RA_W-1:0]   rt_a;
    logic [RA_W-1:0]   rd_a;
    logic [DATA_W-1:0] rs_d;
    logic [DATA_W-1:0] rt_d;
    logic [DATA_W-1:0] imm_ext;
    ctrl_t             dec_ctrl;
    logic              dec_illegal;
    logic              zext;
    logic              hazard;
    logic              ready;
    logic              accept;

    logic              valid_q;
    ctrl_t             ctrl_q;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;
    logic [DATA_W-1:0] imm_q;
    logic [RA_W-1:0]   rtn_q;
    logic [RA_W-1:0]   rdn_q;
    logic [4:0]        shamt_q;
    logic [5:0]        funct_q;
    logic              ill_q;

    assign op   = bus.in_instr[31:26];
    assign rs_a = RA_W'(bus.in_instr[25:21]);
    assign rt_a = RA_W'(bus.in_instr[20:16]);
    assign rd_a = RA_W'(bus.in_instr[15:11]);

    decode_regfile #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .RA_W    (RA_W)
    ) u_rf (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .we    (bus.wb_en),
        .wa    (bus.wb_addr),
        .wd    (bus.wb_data),
        .ra0   (rs_a),
        .ra1   (rt_a),
        .rd0   (rs_d),
        .rd1   (rt_d)
    );

    always_comb begin
        dec_ctrl    = op == OP_RTYPE ? CTRL_R :
                      op == OP_LW    ? CTRL_LW :
                      op == OP_SW    ? CTRL_SW :
                      op == OP_BEQ   ? CTRL_BEQ :
                      op == OP_ADDI  ? CTRL_ADDI :
                      (op == OP_ANDI || op == OP_ORI) ? CTRL_LOGI : '0;
        dec_illegal = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI});
        zext        = LOGIC_ZEXT != 0 && (op == OP_ANDI || op == OP_ORI);
        imm_ext     = zext ? DATA_W'(bus.in_instr[15:0]) : DATA_W'($signed(bus.in_instr[15:0]));
    end

    // A load in the slot whose target feeds the incoming instruction must drain first.
    assign hazard = valid_q && ctrl_q[CTRL_MEMREAD] && rtn_q != '0 && (rtn_q == rs_a || rtn_q == rt_a);
    assign ready  = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept = bus.in_valid && ready;

    // Whenever the slot empties (flush, bubble or drain) ctrl is cleared so no
    // write or memory strobe can leak out of an invalid slot.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            rtn_q   <= '0;
            rdn_q   <= '0;
            shamt_q <= '0;
            funct_q <= '0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec_ctrl;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            imm_q   <= imm_ext;
            rtn_q   <= rt_a;
            rdn_q   <= rd_a;
            shamt_q <= bus.in_instr[10:6];
            funct_q <= bus.in_instr[5:0];
            ill_q   <= dec_illegal;
        end else if (bus.flush || bus.out_ready) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = valid_q;
    assign bus.out_ctrl    = ctrl_q;
    assign bus.out_rs_data = rs_q;
    assign bus.out_rt_data = rt_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_rt      = rtn_q;
    assign bus.out_rd      = rdn_q;
    assign bus.out_shamt   = shamt_q;
    assign bus.out_funct   = funct_q;
    assign bus.out_illegal = ill_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb_decode_pipe_stage: directed and randomized checks of decode_pipe_stage against a
// transaction-level reference model (two DUTs: zero-extending and sign-only immediates).
module tb_decode_pipe_stage;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    decode_pipe_stage_if #(.DATA_W(32), .RA_W(5)) b1 ();
    decode_pipe_stage_if #(.DATA_W(32), .RA_W(5)) b0 ();

    assign b1.in_valid = in_valid;
    assign b1.in_instr = in_instr;
    assign b1.flush = flush;
    assign b1.wb_en = wb_en;
    assign b1.wb_addr = wb_addr;
    assign b1.wb_data = wb_data;
    assign b1.out_ready = out_ready;
    assign b0.in_valid = in_valid;
    assign b0.in_instr = in_instr;
    assign b0.flush = flush;
    assign b0.wb_en = wb_en;
    assign b0.wb_addr = wb_addr;
    assign b0.wb_data = wb_data;
    assign b0.out_ready = out_ready;

    decode_pipe_stage #(.DATA_W(32), .REG_CNT(32), .LOGIC_ZEXT(1)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(b1));
    decode_pipe_stage #(.DATA_W(32), .REG_CNT(32), .LOGIC_ZEXT(0)) dut0 (.Clk(Clk), .Rst_n(Rst_n), .bus(b0));

    // Reference model: architectural registers plus the contents of the ID/EX slot.
    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm1;
        logic [31:0] imm0;
        logic [4:0]  rtn;
        logic [4:0]  rdn;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic        ill;
    } slot_t;

    logic [31:0] m_rf [32];
    logic        m_valid;
    slot_t       m;

    // Control table straight from the instruction list; bit 9 flags an unknown opcode.
    function automatic logic [9:0] ref_dec(input logic [5:0] op);
        case (op)
            6'h00: return {1'b0, 9'b100100010};
            6'h23: return {1'b0, 9'b011110000};
            6'h2B: return {1'b0, 9'b010001000};
            6'h04: return {1'b0, 9'b000000101};
            6'h08: return {1'b0, 9'b010100000};
            6'h0C, 6'h0D: return {1'b0, 9'b010100011};
            default: return {1'b1, 9'b0};
        endcase
    endfunction

    function automatic logic m_ready();
        logic hz;
        hz = m_valid && m.ctrl[4] && m.rtn != 0 && (m.rtn == in_instr[25:21] || m.rtn == in_instr[20:16]);
        return (!m_valid || out_ready) && !hz && !flush;
    endfunction

    function automatic logic [159:0] obs_vec();
        return {b1.out_valid, b1.out_ctrl, b1.out_rs_data, b1.out_rt_data, b1.out_imm, b0.out_imm,
                b1.out_rt, b1.out_rd, b1.out_shamt, b1.out_funct, b1.out_illegal};
    endfunction

    function automatic logic [159:0] exp_vec();
        return {1'b1, m.ctrl, m.rs, m.rt, m.imm1, m.imm0, m.rtn, m.rdn, m.shamt, m.funct, m.ill};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_valid = 1'b0;
        m = '{default: '0};
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
        @(negedge Clk);
        in_valid = v;
        in_instr = ins;
        flush = fl;
        wb_en = we;
        wb_addr = wa;
        wb_data = wd;
        out_ready = ordy;
        #1;
    endtask

    // Advance one clock; the model commits the write-back first, then reads, then updates the slot.
    task automatic tick();
        logic acc;
        logic [9:0] d;
        logic [15:0] im;
        acc = in_valid && m_ready();
        @(posedge Clk);
        if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            d = ref_dec(in_instr[31:26]);
            im = in_instr[15:0];
            m_valid = 1'b1;
            m.ctrl = d[8:0];
            m.ill = d[9];
            m.rs = m_rf[in_instr[25:21]];
            m.rt = m_rf[in_instr[20:16]];
            m.imm0 = {{16{im[15]}}, im};
            m.imm1 = (in_instr[31:26] == 6'h0C || in_instr[31:26] == 6'h0D) ? {16'h0, im} : m.imm0;
            m.rtn = in_instr[20:16];
            m.rdn = in_instr[15:11];
            m.shamt = in_instr[10:6];
            m.funct = in_instr[5:0];
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 32'h0, 0, 0, 0, 0, 0);
        Rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (obs_vec() !== 160'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", obs_vec());
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        checks++;
        if (b1.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=1", b1.in_ready);
        end
    endtask

    task automatic test_basic();
        drive(0, 32'h0, 0, 1, 5'd8, 32'h5, 1);
        tick();
        drive(1, 32'h0100_1820, 0, 0, 0, 0, 1);
        checks++;
        if (b1.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready got=%b want=1", b1.in_ready);
        end
        tick();
        checks++;
        if ({b1.out_valid, b1.out_ctrl, b1.out_rs_data, b1.out_rt_data, b1.out_rd} !== {1'b1, 9'b100100010, 32'd5, 32'd0, 5'd3}) begin
            failures++;
            $display("FAIL basic_add got v=%b c=%b rs=%h rt=%h rd=%0d want v=1 c=100100010 rs=5 rt=0 rd=3",
                     b1.out_valid, b1.out_ctrl, b1.out_rs_data, b1.out_rt_data, b1.out_rd);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL basic_model got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_load_use();
        drive(1, 32'h8C29_0000, 0, 0, 0, 0, 1);
        tick();
        drive(1, 32'h0122_2020, 0, 0, 0, 0, 1);
        checks++;
        if (b1.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_stall got=%b want=0", b1.in_ready);
        end
        tick();
        checks++;
        if ({b1.out_valid, b1.out_ctrl} !== 10'd0) begin
            failures++;
            $display("FAIL loaduse_bubble got v=%b c=%b want v=0 c=0", b1.out_valid, b1.out_ctrl);
        end
        drive(1, 32'h0122_2020, 0, 0, 0, 0, 1);
        checks++;
        if (b1.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL loaduse_release got=%b want=1", b1.in_ready);
        end
        tick();
        checks++;
        if ({b1.out_valid, b1.out_ctrl, b1.out_rd} !== {1'b1, 9'b100100010, 5'd4}) begin
            failures++;
            $display("FAIL loaduse_add got v=%b c=%b rd=%0d want v=1 c=100100010 rd=4", b1.out_valid, b1.out_ctrl, b1.out_rd);
        end
    endtask

    task automatic test_imm();
        logic [31:0] ins [3] = '{32'h30A5_FFFF, 32'h2001_8000, 32'h34A5_8000};
        logic [31:0] w1 [3] = '{32'h0000_FFFF, 32'hFFFF_8000, 32'h0000_8000};
        logic [31:0] w0 [3] = '{32'hFFFF_FFFF, 32'hFFFF_8000, 32'hFFFF_8000};
        for (int i = 0; i < 3; i++) begin
            drive(1, ins[i], 0, 0, 0, 0, 1);
            tick();
            checks++;
            if ({b1.out_imm, b0.out_imm} !== {w1[i], w0[i]}) begin
                failures++;
                $display("FAIL imm_ext[%0d] got zext=%h sext=%h want zext=%h sext=%h", i, b1.out_imm, b0.out_imm, w1[i], w0[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [159:0] held;
        drive(1, 32'h2002_0011, 0, 0, 0, 0, 1);
        tick();
        held = obs_vec();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h2003_0022, 0, 0, 0, 0, 0);
            checks++;
            if (b1.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready[%0d] got=%b want=0", i, b1.in_ready);
            end
            tick();
            checks++;
            if (obs_vec() !== held || held[159] !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%h want=%h", i, obs_vec(), held);
            end
        end
        drive(1, 32'h2003_0022, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({b1.out_valid, b1.out_imm, b1.out_rt} !== {1'b1, 32'h22, 5'd3}) begin
            failures++;
            $display("FAIL bp_release got v=%b imm=%h rt=%0d want v=1 imm=22 rt=3", b1.out_valid, b1.out_imm, b1.out_rt);
        end
    endtask

    task automatic test_bypass();
        drive(1, 32'h00E0_0820, 0, 1, 5'd7, 32'hDEAD_BEEF, 1);
        tick();
        checks++;
        if (b1.out_rs_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h want=deadbeef", b1.out_rs_data);
        end
        drive(1, 32'h0000_1020, 0, 1, 5'd0, 32'h1234, 1);
        tick();
        checks++;
        if ({b1.out_rs_data, b1.out_rt_data} !== 64'd0) begin
            failures++;
            $display("FAIL r0_bypass got rs=%h rt=%h want 0 0", b1.out_rs_data, b1.out_rt_data);
        end
        drive(1, 32'h00E0_1020, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({b1.out_rs_data, b1.out_rt_data} !== {32'hDEAD_BEEF, 32'd0}) begin
            failures++;
            $display("FAIL r0_stored got rs=%h rt=%h want deadbeef 0", b1.out_rs_data, b1.out_rt_data);
        end
    endtask

    task automatic test_flush_illegal();
        drive(1, 32'h2004_0001, 0, 0, 0, 0, 1);
        tick();
        drive(1, 32'h2005_0002, 1, 0, 0, 0, 0);
        checks++;
        if (b1.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b want=0", b1.in_ready);
        end
        tick();
        checks++;
        if ({b1.out_valid, b1.out_ctrl} !== 10'd0) begin
            failures++;
            $display("FAIL flush_drop got v=%b c=%b want 0 0", b1.out_valid, b1.out_ctrl);
        end
        drive(0, 32'h2005_0002, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if (b1.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_not_accepted got=%b want=0", b1.out_valid);
        end
        drive(1, 32'hFC00_0000, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({b1.out_valid, b1.out_illegal, b1.out_ctrl} !== {1'b1, 1'b1, 9'd0}) begin
            failures++;
            $display("FAIL illegal got v=%b ill=%b c=%b want 1 1 0", b1.out_valid, b1.out_illegal, b1.out_ctrl);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h3F, 6'h23};
        logic [31:0] ins;
        int bad_ready = 0;
        int bad_out = 0;
        for (int n = 0; n < 500; n++) begin
            ins = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            if ($urandom_range(0, 15) == 0) ins[31:26] = 6'($urandom);
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 7);
            checks++;
            if (b1.in_ready !== m_ready()) begin
                failures++;
                if (bad_ready++ < 5) $display("FAIL rand_ready cyc=%0d got=%b want=%b", n, b1.in_ready, m_ready());
            end
            tick();
            checks++;
            if (m_valid ? (obs_vec() !== exp_vec()) : ({b1.out_valid, b1.out_ctrl} !== 10'd0)) begin
                failures++;
                if (bad_out++ < 5) $display("FAIL rand_slot cyc=%0d mv=%b got=%h want=%h", n, m_valid, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 32'h00E0_0820, 0, 1, 5'd7, 32'h0BAD_F00D, 1);
        tick();
        drive(1, 32'h2006_0003, 0, 0, 0, 0, 0);
        #1;
        Rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({b1.out_valid, b1.out_ctrl, b1.out_rs_data} !== 42'd0) begin
            failures++;
            $display("FAIL reset_mid got v=%b c=%b rs=%h want 0", b1.out_valid, b1.out_ctrl, b1.out_rs_data);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        drive(1, 32'h00E0_0820, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({b1.out_valid, b1.out_rs_data} !== {1'b1, 32'd0}) begin
            failures++;
            $display("FAIL reset_rf_clear got v=%b rs=%h want v=1 rs=0", b1.out_valid, b1.out_rs_data);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_load_use();
        test_imm();
        test_backpressure();
        test_bypass();
        test_flush_illegal();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
